// File: rtl/exc_vector_seq.sv
// Exception vector sequencer: save EPC, address vector byte, wait MEM_LAT, load PC (EXC_CAUSE_REG_EN keeps causeOut after exit).
// Latency: busy for 2+MEM_LAT cycles from the edge that accepts a request; PC write in the last busy cycle.
// Backpressure: none accepted; requests arriving while busy are dropped, and busy stalls the control unit.
module exc_vector_seq #(
  parameter int unsigned MEM_LAT = 2,
  parameter logic [31:0] EPC_ADJ = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        excOpcode,
  input  logic        excOverflow,
  input  logic        excDivZero,
  input  logic [31:0] pcOut,
  input  logic [31:0] memData,
  output logic [2:0]  excIordmux,
  output logic [31:0] epcOut,
  output logic        epcWrite,
  output logic [31:0] pcExcValue,
  output logic        pcSrcExc,
  output logic        pcWrite,
  output logic        busy,
  output logic [1:0]  causeOut
);

  typedef enum logic [1:0] {IDLE, SAVE, WAIT, LOAD} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  cause_q, cause_d;
  logic        busy_q, busy_d;
  logic        epc_we_q, epc_we_d;
  logic        pc_we_q, pc_we_d;

  logic [1:0]  req_cause;
  logic [2:0]  req_sel;

  // Only the low byte of memory data carries the vector.
  logic        unused_mem_hi;
  assign unused_mem_hi = ^memData[31:8];

  always_comb begin
    req_cause = 2'd0;
    req_sel   = 3'b000;
    if (excOpcode) begin
      req_cause = 2'd1;
      req_sel   = 3'b011;
    end else if (excOverflow) begin
      req_cause = 2'd2;
      req_sel   = 3'b100;
    end else if (excDivZero) begin
      req_cause = 2'd3;
      req_sel   = 3'b101;
    end
  end

  // Strobes are computed one cycle ahead so they leave the block straight from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    cause_d  = cause_q;
    busy_d   = busy_q;
    epc_we_d = 1'b0;
    pc_we_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_cause != 2'd0) begin
          state_d  = SAVE;
          sel_d    = req_sel;
          cause_d  = req_cause;
          busy_d   = 1'b1;
          epc_we_d = 1'b1;
        end
      end
      SAVE: begin
        cnt_d = LAT;
        if (LAT != 3'd0) begin
          state_d = WAIT;
        end else begin
          state_d = LOAD;
          pc_we_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = LOAD;
          pc_we_d = 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sel_d   = 3'b000;
`ifdef EXC_CAUSE_REG_EN
        cause_d = cause_q;
`else
        cause_d = 2'd0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sel_q    <= 3'b000;
      cause_q  <= 2'd0;
      busy_q   <= 1'b0;
      epc_we_q <= 1'b0;
      pc_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cause_q  <= cause_d;
      busy_q   <= busy_d;
      epc_we_q <= epc_we_d;
      pc_we_q  <= pc_we_d;
    end
  end

  assign excIordmux = sel_q;
  assign busy       = busy_q;
  assign epcWrite   = epc_we_q;
  assign epcOut     = epc_we_q ? (pcOut - EPC_ADJ) : 32'd0;
  assign pcWrite    = pc_we_q;
  assign pcSrcExc   = pc_we_q;
  assign pcExcValue = pc_we_q ? {24'd0, memData[7:0]} : 32'd0;
  assign causeOut   = cause_q;

endmodule

// File: tb/tb_exc_vector_seq.sv
// Bench for exc_vector_seq: two instances (MEM_LAT=2 and MEM_LAT=0) share stimulus and are
// compared every cycle against a phase-based reference model, plus directed literal checks.
module tb_exc_vector_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        excOpcode = 1'b0;
  logic        excOverflow = 1'b0;
  logic        excDivZero = 1'b0;
  logic [31:0] pcOut = 32'd0;
  logic [31:0] memData = 32'd0;

  logic [2:0]  sel[2];
  logic [31:0] epc_out[2];
  logic        epc_we[2];
  logic [31:0] pc_val[2];
  logic        pc_src[2];
  logic        pc_we[2];
  logic        busy[2];
  logic [1:0]  cause[2];

`ifdef EXC_CAUSE_REG_EN
  localparam logic [1:0] IDLE_CAUSE_T2 = 2'd2;
`else
  localparam logic [1:0] IDLE_CAUSE_T2 = 2'd0;
`endif

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_LAT(2), .EPC_ADJ(32'd4)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .excOpcode(excOpcode), .excOverflow(excOverflow), .excDivZero(excDivZero),
    .pcOut(pcOut), .memData(memData),
    .excIordmux(sel[0]), .epcOut(epc_out[0]), .epcWrite(epc_we[0]),
    .pcExcValue(pc_val[0]), .pcSrcExc(pc_src[0]), .pcWrite(pc_we[0]),
    .busy(busy[0]), .causeOut(cause[0])
  );

  exc_vector_seq #(.MEM_LAT(0), .EPC_ADJ(32'd4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .excOpcode(excOpcode), .excOverflow(excOverflow), .excDivZero(excDivZero),
    .pcOut(pcOut), .memData(memData),
    .excIordmux(sel[1]), .epcOut(epc_out[1]), .epcWrite(epc_we[1]),
    .pcExcValue(pc_val[1]), .pcSrcExc(pc_src[1]), .pcWrite(pc_we[1]),
    .busy(busy[1]), .causeOut(cause[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase = index of the current busy cycle (-1 when idle).
  int         phase[2];
  logic [1:0] last_cause[2];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [1:0] pick(input logic o, input logic v, input logic d);
    if (o) return 2'd1;
    if (v) return 2'd2;
    if (d) return 2'd3;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        phase[i]      <= -1;
        last_cause[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (phase[i] >= 0) begin
          phase[i] <= (phase[i] == lat(i) + 1) ? -1 : phase[i] + 1;
        end else if (pick(excOpcode, excOverflow, excDivZero) != 2'd0) begin
          phase[i]      <= 0;
          last_cause[i] <= pick(excOpcode, excOverflow, excDivZero);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, i, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    logic       b;
    logic       ew;
    logic       pw;
    logic [2:0] es;
    logic [1:0] ec;
    b  = (phase[i] >= 0);
    ew = (phase[i] == 0);
    pw = (phase[i] == lat(i) + 1);
    es = b ? (3'(last_cause[i]) + 3'd2) : 3'd0;
`ifdef EXC_CAUSE_REG_EN
    ec = last_cause[i];
`else
    ec = b ? last_cause[i] : 2'd0;
`endif
    chk("busy", i, 32'(busy[i]), 32'(b));
    chk("excIordmux", i, 32'(sel[i]), 32'(es));
    chk("epcWrite", i, 32'(epc_we[i]), 32'(ew));
    chk("epcOut", i, epc_out[i], ew ? (pcOut - 32'd4) : 32'd0);
    chk("pcWrite", i, 32'(pc_we[i]), 32'(pw));
    chk("pcSrcExc", i, 32'(pc_src[i]), 32'(pw));
    chk("pcExcValue", i, pc_val[i], pw ? {24'd0, memData[7:0]} : 32'd0);
    chk("causeOut", i, 32'(cause[i]), 32'(ec));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1, pw;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_sel", 0, 32'(sel[0]), 32'd0);
    chk("rst_cause", 0, 32'(cause[0]), 32'd0);
    chk("rst_pcw", 0, 32'(pc_we[0]), 32'd0);

    // Opcode exception: EPC 0x40-4, vector byte 0x9A from a word with junk upper bits.
    cyc();
    excOpcode = 1'b1;
    pcOut     = 32'h0000_0040;
    memData   = 32'hFFFF_FF9A;
    cyc();
    excOpcode = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (k == 0) begin
        chk("t1_epcw", 0, 32'(epc_we[0]), 32'd1);
        chk("t1_epc", 0, epc_out[0], 32'h3C);
        chk("t1_sel", 0, 32'(sel[0]), 32'd3);
        chk("t1_cause", 0, 32'(cause[0]), 32'd1);
      end
      if (k == 1) chk("t1_vec", 1, pc_val[1], 32'h9A);
      if (k == 3) begin
        chk("t1_pcw", 0, 32'(pc_we[0]), 32'd1);
        chk("t1_src", 0, 32'(pc_src[0]), 32'd1);
        chk("t1_vec", 0, pc_val[0], 32'h9A);
      end
    end
    chk("t1_busy_len", 0, n0, 32'd4);
    chk("t1_busy_len", 1, n1, 32'd2);

    // Overflow and divzero together, EPC wraps from pcOut=0; divzero retried during WAIT.
    cyc();
    excOverflow = 1'b1;
    excDivZero  = 1'b1;
    pcOut       = 32'd0;
    cyc();
    excOverflow = 1'b0;
    excDivZero  = 1'b0;
    @(negedge clk);
    chk("t2_sel", 0, 32'(sel[0]), 32'd4);
    chk("t2_sel", 1, 32'(sel[1]), 32'd4);
    chk("t2_cause", 0, 32'(cause[0]), 32'd2);
    chk("t2_epc_wrap", 0, epc_out[0], 32'hFFFF_FFFC);
    cyc();
    excDivZero = 1'b1;
    cyc();
    excDivZero = 1'b0;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy[0]) n0++;
      else chk("t2_cause_idle", 0, 32'(cause[0]), 32'(IDLE_CAUSE_T2));
    end
    chk("t2_busy_len", 0, n0, 32'd2);

    // Asynchronous reset while dut0 is in WAIT and dut1 is in LOAD.
    cyc();
    excOpcode = 1'b1;
    pcOut     = 32'h0000_0100;
    cyc();
    excOpcode = 1'b0;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t3_busy", 0, 32'(busy[0]), 32'd0);
    chk("t3_sel", 0, 32'(sel[0]), 32'd0);
    chk("t3_cause", 0, 32'(cause[0]), 32'd0);
    chk("t3_pcw", 1, 32'(pc_we[1]), 32'd0);
    chk("t3_vec", 1, pc_val[1], 32'd0);
    cyc();
    reset_n = 1'b1;
    pw = 0;
    n0 = 0;
    repeat (6) begin
      @(negedge clk);
      if (pc_we[0]) pw++;
      if (busy[0]) n0++;
    end
    chk("t3_no_pcw", 0, pw, 32'd0);
    chk("t3_idle", 0, n0, 32'd0);

    // Random traffic with occasional mid-cycle asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      excOpcode   = ($urandom_range(0, 7) == 0);
      excOverflow = ($urandom_range(0, 5) == 0);
      excDivZero  = ($urandom_range(0, 4) == 0);
      pcOut       = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      memData     = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
